// File: rtl/pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_unit_pkg
// Shared definitions for the program-counter unit and its return-address
// stack.
//   - pc_op_t       : 3-bit operation code presented by instruction decode
//   - PC_OP_*       : operation encodings (6 and 7 are reserved, act as HOLD)
//   - PC_DEFAULT_AW : default address width
// ---------------------------------------------------------------------------
package pc_unit_pkg;

    localparam int PC_DEFAULT_AW = 13;

    typedef logic [2:0] pc_op_t;

    localparam pc_op_t PC_OP_INC  = 3'd0;
    localparam pc_op_t PC_OP_JMP  = 3'd1;
    localparam pc_op_t PC_OP_BR   = 3'd2;
    localparam pc_op_t PC_OP_CALL = 3'd3;
    localparam pc_op_t PC_OP_RET  = 3'd4;
    localparam pc_op_t PC_OP_HOLD = 3'd5;

endpackage

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
// Return-address stack: a small LIFO of AW-bit addresses.
// When a push arrives while full, the stack behaves circularly: the oldest
// entry is overwritten, the count stays at DEPTH and err is set.
// A pop while empty leaves the stack unchanged and sets err.
// err is sticky until rst.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data as the new top entry
//   pop        : discard the top entry (push and pop are never both set)
//   push_data  : address to push
//   top_data   : current top entry (valid when !empty)
//   empty/full : decoded from the registered entry count
//   err        : sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int AW    = PC_DEFAULT_AW,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top_data,
    output logic          empty,
    output logic          full,
    output logic          err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0] tos;
    logic [PW-1:0] tos_up;
    logic [PW:0]   count;
    logic [AW-1:0] mem [DEPTH];

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign tos_up   = tos + 1'b1;
    assign top_data = mem[tos];
    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tos   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (push) begin
            tos <= tos_up;
            if (full) begin
                err <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                err <= 1'b1;
            end else begin
                tos   <= tos - 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset; when full, tos_up lands on the oldest
    // entry, which is exactly the one to overwrite.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tos_up] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program-counter unit: increment, absolute jump, PC-relative branch,
// hold/stall and call/return through a hardware return-address stack.
//
// Optional build macro: PC_TRACE_EN adds prev_pc and redirect outputs.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   stall      : freeze pc, stack and error flag; op is ignored
//   op         : operation code (see pc_unit_pkg)
//   target     : absolute address for JMP/CALL
//   offset     : two's-complement displacement for BR
//   pc         : registered program counter
//   pc_next    : value pc takes at the next clock edge
//   ras_empty  : return-address stack holds no entries
//   ras_full   : return-address stack holds RAS_DEPTH entries
//   ras_err    : sticky stack overflow/underflow flag
//   prev_pc    : (PC_TRACE_EN) pc before the last non-stalled update
//   redirect   : (PC_TRACE_EN) last update was a taken control transfer
// ---------------------------------------------------------------------------
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int            AW         = PC_DEFAULT_AW,
    parameter int            RAS_DEPTH  = 4,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic [2:0]    op,
    input  logic [AW-1:0] target,
    input  logic [AW-1:0] offset,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_next,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_err
`ifdef PC_TRACE_EN
    ,
    output logic [AW-1:0] prev_pc,
    output logic          redirect
`endif
);

    pc_op_t        op_t;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] ras_top;
    logic          ras_push;
    logic          ras_pop;

    assign op_t = pc_op_t'(op);

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
        return a + 1'b1;
    endfunction

    // Sign-extend the displacement and keep the low AW bits (modulo 2^AW).
    function automatic logic [AW-1:0] wrap_add(input logic        [AW-1:0] base,
                                               input logic signed [AW-1:0] disp);
        logic signed [AW:0] sum;
        sum = $signed({1'b0, base}) + disp;
        return sum[AW-1:0];
    endfunction

    always_comb begin
        pc_inc   = wrap_inc(pc);
        pc_next  = pc;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!stall) begin
            case (op_t)
                PC_OP_INC:  pc_next = pc_inc;
                PC_OP_JMP:  pc_next = target;
                PC_OP_BR:   pc_next = wrap_add(pc, $signed(offset));
                PC_OP_CALL: begin
                    ras_push = 1'b1;
                    pc_next  = target;
                end
                PC_OP_RET: begin
                    // An underflowing return falls through to the next address.
                    ras_pop = 1'b1;
                    pc_next = ras_empty ? pc_inc : ras_top;
                end
                default:    pc_next = pc;
            endcase
        end
    end

    pc_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .err       (ras_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_ADDR;
        end else begin
            pc <= pc_next;
        end
    end

`ifdef PC_TRACE_EN
    logic redirect_d;

    // A branch by +1 lands on the sequential address, so it is not a redirect.
    assign redirect_d = !stall &&
                        ((op_t == PC_OP_JMP)  ||
                         (op_t == PC_OP_CALL) ||
                         ((op_t == PC_OP_BR)  && (offset != AW'(1))) ||
                         ((op_t == PC_OP_RET) && !ras_empty));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc  <= RESET_ADDR;
            redirect <= 1'b0;
        end else begin
            redirect <= redirect_d;
            if (!stall) begin
                prev_pc <= pc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Self-checking bench for pc_unit. A behavioural model (pc value plus a
// queue of return addresses) predicts the state after each operation; the
// prediction is queued and a monitor compares it with the DUT every cycle.
// ---------------------------------------------------------------------------
module tb_pc_unit;
    import pc_unit_pkg::*;

    localparam int AW    = 13;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic [AW-1:0] offset;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_err;
`ifdef PC_TRACE_EN
    logic [AW-1:0] prev_pc;
    logic          redirect;
`endif

    pc_unit #(
        .AW         (AW),
        .RAS_DEPTH  (DEPTH),
        .RESET_ADDR (13'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .op        (op),
        .target    (target),
        .offset    (offset),
        .pc        (pc),
        .pc_next   (pc_next),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
`ifdef PC_TRACE_EN
        ,
        .prev_pc   (prev_pc),
        .redirect  (redirect)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          empty;
        logic          full;
        logic          err;
        logic [AW-1:0] prev;
        logic          redir;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [AW-1:0] pc_m;
    logic [AW-1:0] stk[$];
    logic          err_m;
    logic [AW-1:0] prev_m;
    logic          redir_m;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic model_reset();
        pc_m    = 13'd0;
        stk.delete();
        err_m   = 1'b0;
        prev_m  = 13'd0;
        redir_m = 1'b0;
    endtask

    // Apply one operation for one clock cycle, predict its outcome, and
    // queue the prediction for the monitor.
    task automatic do_op(input logic [2:0] o, input logic [AW-1:0] t,
                         input logic [AW-1:0] off, input logic st);
        logic [AW-1:0] nxt;
        logic          rd;
        exp_t          e;
        @(negedge clk);
        #1;
        op     = o;
        target = t;
        offset = off;
        stall  = st;
        nxt    = pc_m;
        rd     = 1'b0;
        if (!st) begin
            if (o == PC_OP_INC) begin
                nxt = pc_m + 13'd1;
            end else if (o == PC_OP_JMP) begin
                nxt = t;
                rd  = 1'b1;
            end else if (o == PC_OP_BR) begin
                nxt = pc_m + off;
                rd  = (off != 13'd1);
            end else if (o == PC_OP_CALL) begin
                if (stk.size() == DEPTH) begin
                    void'(stk.pop_front());
                    err_m = 1'b1;
                end
                stk.push_back(pc_m + 13'd1);
                nxt = t;
                rd  = 1'b1;
            end else if (o == PC_OP_RET) begin
                if (stk.size() > 0) begin
                    nxt = stk.pop_back();
                    rd  = 1'b1;
                end else begin
                    nxt   = pc_m + 13'd1;
                    err_m = 1'b1;
                end
            end
            prev_m = pc_m;
        end
        #1;
        chk("pc_next", pc_next, nxt);
        pc_m    = nxt;
        redir_m = rd;
        e.pc    = pc_m;
        e.empty = (stk.size() == 0);
        e.full  = (stk.size() == DEPTH);
        e.err   = err_m;
        e.prev  = prev_m;
        e.redir = redir_m;
        exp_q.push_back(e);
    endtask

    // Monitor: the DUT presents a new pc every cycle; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("ras_empty", ras_empty, e.empty);
                chk("ras_full", ras_full, e.full);
                chk("ras_err", ras_err, e.err);
`ifdef PC_TRACE_EN
                chk("prev_pc", prev_pc, e.prev);
                chk("redirect", redirect, e.redir);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] t;
        logic [AW-1:0] off;
        logic [2:0]    o;
        logic          st;

        rst    = 1'b1;
        stall  = 1'b0;
        op     = PC_OP_HOLD;
        target = '0;
        offset = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pc", pc, 13'd0);
        chk("reset_empty", ras_empty, 1'b1);
        chk("reset_full", ras_full, 1'b0);
        chk("reset_err", ras_err, 1'b0);
        #1 rst = 1'b0;

        // Increment from reset
        repeat (3) do_op(PC_OP_INC, '0, '0, 1'b0);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("inc3_pc", pc, 13'd3);

        // Wrap-around
        do_op(PC_OP_JMP, 13'h1FFF, '0, 1'b0);
        do_op(PC_OP_INC, '0, '0, 1'b0);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("wrap_pc", pc, 13'h0000);
        do_op(PC_OP_JMP, 13'd5, '0, 1'b0);
        do_op(PC_OP_BR, '0, 13'h1FFF, 1'b0);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("br_minus1_pc", pc, 13'd4);

        // Nested call/return
        do_op(PC_OP_JMP, 13'd10, '0, 1'b0);
        do_op(PC_OP_CALL, 13'd100, '0, 1'b0);
        do_op(PC_OP_CALL, 13'd200, '0, 1'b0);
        do_op(PC_OP_RET, '0, '0, 1'b0);
        do_op(PC_OP_RET, '0, '0, 1'b0);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("nest_pc", pc, 13'd11);
        chk("nest_empty", ras_empty, 1'b1);
        chk("nest_err", ras_err, 1'b0);

        // Underflow
        do_op(PC_OP_JMP, 13'd7, '0, 1'b0);
        do_op(PC_OP_RET, '0, '0, 1'b0);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("underflow_pc", pc, 13'd8);
        chk("underflow_err", ras_err, 1'b1);

        // Stall overrides a jump
        do_op(PC_OP_JMP, 13'd300, '0, 1'b1);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("stall_pc", pc, 13'd8);

        // Overflow: five calls into a four-entry stack, then four returns
        do_op(PC_OP_JMP, 13'd0, '0, 1'b0);
        for (int i = 0; i < 5; i++) do_op(PC_OP_CALL, 13'(20 + 10 * i), '0, 1'b0);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("ovf_full", ras_full, 1'b1);
        chk("ovf_err", ras_err, 1'b1);
        for (int i = 0; i < 4; i++) do_op(PC_OP_RET, '0, '0, 1'b0);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("ovf_drain_empty", ras_empty, 1'b1);

        // Asynchronous reset between clock edges after two calls
        do_op(PC_OP_CALL, 13'd400, '0, 1'b0);
        do_op(PC_OP_CALL, 13'd500, '0, 1'b0);
        @(negedge clk);
        #1;
        op = PC_OP_HOLD;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", pc, 13'd0);
        chk("async_rst_empty", ras_empty, 1'b1);
        chk("async_rst_err", ras_err, 1'b0);
        rst = 1'b0;
        model_reset();
        do_op(PC_OP_INC, '0, '0, 1'b0);
        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        chk("post_rst_inc_pc", pc, 13'd1);

        // Randomized operation mix
        for (int i = 0; i < 400; i++) begin
            o  = 3'($urandom_range(0, 7));
            st = ($urandom_range(0, 9) == 0);
            t  = 13'($urandom());
            case ($urandom_range(0, 3))
                0:       off = 13'd1;
                1:       off = 13'h1FFF;
                default: off = 13'($urandom());
            endcase
            do_op(o, t, off, st);
        end

        do_op(PC_OP_HOLD, '0, '0, 1'b0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
